// File: rtl/bin2bcd_disp_if.sv
// Request/result bundle between a binary source and the BCD converter feeding
// the seven-segment scan driver.
interface bin2bcd_disp_if #(
    parameter int IN_W   = 27,
    parameter int DIGITS = 8
);
    logic                  start;
    logic [IN_W-1:0]       bin;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  done;
    logic                  ovf;

    modport master (output start, bin, input bcd, busy, done, ovf);
    modport slave  (input start, bin, output bcd, busy, done, ovf);
endinterface

// File: rtl/bin2bcd_disp.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// The bcd/ovf outputs only move on the DONE cycle so a scanned display never shows a partial value.
module bin2bcd_disp #(
    parameter int          IN_W    = 27,
    parameter int          DIGITS  = 8,
    parameter int unsigned MAX_VAL = 99_999_999
) (
    input  logic           clk,
    input  logic           rst_n,
    bin2bcd_disp_if.slave  bus
);
    localparam int              BW      = 4 * DIGITS;
    localparam int              CW      = $clog2(IN_W);
    localparam logic [IN_W-1:0] MAX_BIN = IN_W'(MAX_VAL);
    localparam logic [CW-1:0]   LAST    = CW'(IN_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_nxt;
    logic [IN_W-1:0] shreg;
    logic [BW-1:0]   work;
    logic [BW-1:0]   adj;
    logic [CW-1:0]   cnt;
    logic            ovf_n;
    logic [BW-1:0]   bcd_q;
    logic            busy_q;
    logic            done_q;
    logic            ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Nibbles are at most 9 after each shift, so +3 tops out at 4'hC: no inter-nibble carry.
    always_comb begin
        adj = work;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            work   <= '0;
            cnt    <= '0;
            ovf_n  <= 1'b0;
            bcd_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg  <= bus.bin;
                        work   <= '0;
                        cnt    <= '0;
                        ovf_n  <= (bus.bin > MAX_BIN);
                        busy_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    work  <= {adj[BW-2:0], shreg[IN_W-1]};
                    shreg <= {shreg[IN_W-2:0], 1'b0};
                    cnt   <= cnt + 1'b1;
                end
                DONE: begin
                    bcd_q  <= ovf_n ? {DIGITS{4'hE}} : work;
                    ovf_q  <= ovf_n;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.bcd  = bcd_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
endmodule
